// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Packet-granular round-robin arbiter that shares one FIFO write port
//   between N_REQ streaming requesters. It also sequences the FIFO reset:
//   fifo_rst is held for RST_CYCLES, then writes are held off for at least
//   GUARD_CYCLES and until fifo_wr_rst_busy clears. The whole block runs on
//   the FIFO write clock.
//
//   Optional feature macro: FIFO_ARB_PROG_FULL_THROTTLE_EN
//     defined   : IDLE issues no new grant while fifo_prog_full is high.
//     undefined : fifo_prog_full is ignored.
//
// Ports
//   clk, reset          write clock, async active-high reset
//   fifo_init           1-cycle request to re-run the FIFO reset sequence
//   req_data/valid/last per-requester stream (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready           per-requester word accept
//   grant               registered one-hot grant, zero when idle
//   busy                high while the FIFO reset sequence runs
//   fifo_rst/din/wr_en  FIFO write-side controls
//   fifo_full, fifo_wr_rst_busy, fifo_prog_full  FIFO status
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH   = 18,
    parameter int N_REQ        = 4,
    parameter int RST_CYCLES   = 4,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fifo_init,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy,
    output logic                        fifo_rst,
    output logic [DATA_WIDTH-1:0]       fifo_din,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    input  logic                        fifo_wr_rst_busy,
    input  logic                        fifo_prog_full
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {RST_ASSERT, RST_WAIT, IDLE, XFER} state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0]     r_grant, w_grant_nxt;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
    logic                 r_init_pend, w_init_pend_nxt;

    logic                 w_found;
    logic [N_REQ-1:0]     w_sel_oh;
    logic [PTR_W-1:0]     w_gidx;
    logic [DATA_WIDTH-1:0] w_din;
    logic [N_REQ-1:0]     w_accept;
    logic                 w_pkt_end;
    logic                 w_start_ok;

`ifdef FIFO_ARB_PROG_FULL_THROTTLE_EN
    assign w_start_ok = ~fifo_prog_full;
`else
    logic w_unused_prog_full;
    assign w_unused_prog_full = fifo_prog_full;
    assign w_start_ok = 1'b1;
`endif

    // Round-robin pick: first pass covers requesters at or above the pointer,
    // second pass wraps to the ones below it. Constant indices keep it simple.
    always_comb begin
        w_found  = 1'b0;
        w_sel_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid[i] && (PTR_W'(i) >= r_ptr)) begin
                w_found     = 1'b1;
                w_sel_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found     = 1'b1;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    // Granted index and AND-OR data mux; grant is one-hot or zero.
    always_comb begin
        w_gidx = '0;
        w_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx = PTR_W'(i);
                w_din  = w_din | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready uses the current-cycle full flag, so no write lands while full.
    assign req_ready  = (r_state == XFER && !fifo_full && !fifo_wr_rst_busy) ? r_grant : '0;
    assign w_accept   = req_valid & req_ready;
    assign w_pkt_end  = |(w_accept & req_last);
    assign fifo_wr_en = |w_accept;
    assign fifo_din   = w_din;
    assign grant      = r_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RST_ASSERT;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_init_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
            r_init_pend <= w_init_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_grant_nxt     = r_grant;
        w_ptr_nxt       = r_ptr;
        w_init_pend_nxt = r_init_pend;
        fifo_rst        = 1'b0;
        busy            = 1'b0;
        case (r_state)
            RST_ASSERT: begin
                fifo_rst = 1'b1;
                busy     = 1'b1;
                if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = RST_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RST_WAIT: begin
                busy = 1'b1;
                // Counter saturates once the guard time has elapsed; then only
                // wr_rst_busy keeps us here.
                if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                    if (!fifo_wr_rst_busy) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (fifo_init || r_init_pend) begin
                    w_init_pend_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = RST_ASSERT;
                end else if (w_found && w_start_ok) begin
                    w_grant_nxt = w_sel_oh;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                // A re-init request waits for the open packet to finish.
                if (fifo_init) w_init_pend_nxt = 1'b1;
                if (w_pkt_end) begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = RST_ASSERT;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int W = 18;
    localparam int N = 4;
    localparam logic [N-1:0] PKT_G [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                            4'b0100, 4'b0100, 4'b0100, 4'b0000};

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           fifo_init = 1'b0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           fifo_rst;
    logic [W-1:0]   fifo_din;
    logic           fifo_wr_en;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_rst_busy = 1'b1;
    logic           fifo_prog_full = 1'b0;

    fifo_wr_arbiter #(.DATA_WIDTH(W), .N_REQ(N), .RST_CYCLES(4), .GUARD_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .fifo_init(fifo_init),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .busy(busy), .fifo_rst(fifo_rst),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .fifo_wr_rst_busy(fifo_wr_rst_busy), .fifo_prog_full(fifo_prog_full)
    );

    always #5 clk = ~clk;

    logic [W-1:0] rq_d [N][$];
    logic         rq_l [N][$];
    logic [W-1:0] sb [$];
    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: every FIFO write must match the next expected word.
    always @(negedge clk) begin
        if (!reset && fifo_wr_en) begin
            logic [W-1:0] exp_w;
            n_cmp++;
            if (fifo_full) begin
                n_err++;
                $display("FAIL wr_while_full: wr_en=1 with full=1");
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: din=%h with empty scoreboard", fifo_din);
            end else begin
                exp_w = sb.pop_front();
                if (fifo_din !== exp_w) begin
                    n_err++;
                    $display("FAIL fifo_din: got %h want %h", fifo_din, exp_w);
                end
            end
        end
    end

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (rq_d[r].size() > 0) begin
                req_valid[r]       = 1'b1;
                req_data[r*W +: W] = rq_d[r][0];
                req_last[r]        = rq_l[r][0];
            end else begin
                req_valid[r]       = 1'b0;
                req_data[r*W +: W] = '0;
                req_last[r]        = 1'b0;
            end
        end
    endtask

    // One clock: handshakes seen before the edge retire requester words after it.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (hs[r]) begin
                void'(rq_d[r].pop_front());
                void'(rq_l[r].pop_front());
            end
        end
        drive();
    endtask

    task automatic load_pkt(input int r, input int n, input logic [W-1:0] base);
        for (int j = 0; j < n; j++) begin
            rq_d[r].push_back(base + W'(j));
            rq_l[r].push_back(j == n - 1);
        end
        drive();
    endtask

    task automatic test_reset();
        int rst_cnt, first_idle, first_gnt;
        logic [N-1:0] g1;
        reset = 1'b1;
        fifo_wr_rst_busy = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({fifo_rst, busy} !== 2'b11) begin
            n_err++; $display("FAIL reset_rst_busy: got %b want 11", {fifo_rst, busy});
        end
        n_cmp++;
        if (grant !== '0) begin
            n_err++; $display("FAIL reset_grant: got %b want 0000", grant);
        end
        load_pkt(3, 1, 18'h3F0);
        sb.push_back(18'h3F0);
        step();
        n_cmp++;
        if ({fifo_wr_en, req_ready} !== 5'b0) begin
            n_err++; $display("FAIL reset_wr_ready: got %b want 00000", {fifo_wr_en, req_ready});
        end
        reset = 1'b0;
        rst_cnt = int'(fifo_rst);
        first_idle = 0; first_gnt = 0; g1 = '0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (fifo_rst) rst_cnt++;
            if (!busy && first_idle == 0) first_idle = c;
            if (grant != '0 && first_gnt == 0) begin
                first_gnt = c; g1 = grant;
            end
            if (c == 20) fifo_wr_rst_busy = 1'b0;
        end
        n_cmp++;
        if (rst_cnt != 4) begin
            n_err++; $display("FAIL rst_pulse_len: got %0d want 4", rst_cnt);
        end
        // busy input falls after edge 20, so RST_WAIT exits on edge 21.
        n_cmp++;
        if (first_idle != 21) begin
            n_err++; $display("FAIL busy_fall_cycle: got %0d want 21", first_idle);
        end
        n_cmp++;
        if (first_gnt != 22 || g1 !== 4'b1000) begin
            n_err++; $display("FAIL first_grant: got cycle %0d grant %b want 22 1000", first_gnt, g1);
        end
    endtask

    task automatic test_packets();
        load_pkt(0, 3, 18'h0A0);
        load_pkt(2, 3, 18'h0C0);
        for (int j = 0; j < 3; j++) sb.push_back(18'h0A0 + W'(j));
        for (int j = 0; j < 3; j++) sb.push_back(18'h0C0 + W'(j));
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (grant !== PKT_G[c]) begin
                n_err++; $display("FAIL pkt_grant[%0d]: got %b want %b", c, grant, PKT_G[c]);
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL pkt_drain: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        int seen = 0;
        int r;
        logic [N-1:0] exp_g;
        for (int t = 0; t < 3; t++)
            for (int q = 0; q < N; q++) load_pkt(q, 1, 18'h100 + W'(16*q + t));
        // Pointer sits at 3 after the previous packet from requester 2.
        for (int t = 0; t < 3; t++)
            for (int off = 0; off < N; off++) begin
                r = (3 + off) % N;
                sb.push_back(18'h100 + W'(16*r + t));
            end
        for (int c = 0; c < 40 && seen < 12; c++) begin
            step();
            if (grant != '0) begin
                exp_g = '0;
                exp_g[(3 + seen) % N] = 1'b1;
                n_cmp++;
                if (grant !== exp_g) begin
                    n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", seen, grant, exp_g);
                end
                seen++;
            end
        end
        n_cmp++;
        if (seen != 12) begin
            n_err++; $display("FAIL rr_count: got %0d want 12", seen);
        end
        repeat (2) step();
    endtask

    task automatic test_full_stall();
        bit done = 1'b0;
        load_pkt(3, 4, 18'h0D0);
        for (int j = 0; j < 4; j++) sb.push_back(18'h0D0 + W'(j));
        step();
        n_cmp++;
        if (grant !== 4'b1000) begin
            n_err++; $display("FAIL stall_grant0: got %b want 1000", grant);
        end
        step();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if ({fifo_wr_en, req_ready, grant} !== 9'b0_0000_1000) begin
                n_err++;
                $display("FAIL stall[%0d]: got wr=%b rdy=%b gnt=%b want 0 0000 1000", k, fifo_wr_en, req_ready, grant);
            end
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            if (grant == '0) done = 1'b1;
        end
        n_cmp++;
        if (!done || sb.size() != 0) begin
            n_err++; $display("FAIL stall_finish: got done=%0d left=%0d want 1 0", done, sb.size());
        end
    endtask

    task automatic test_init_mid_packet();
        int rst_cnt = 0, first_rst = 0, bad_gnt = 0;
        load_pkt(1, 4, 18'h1B0);
        for (int j = 0; j < 4; j++) sb.push_back(18'h1B0 + W'(j));
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c <= 4) begin
                n_cmp++;
                if (grant !== 4'b0010) begin
                    n_err++; $display("FAIL init_pkt_grant[%0d]: got %b want 0010", c, grant);
                end
            end
            if (fifo_rst) begin
                rst_cnt++;
                if (first_rst == 0) first_rst = c;
            end
            if (c == 6) begin
                n_cmp++;
                if (sb.size() != 1) begin
                    n_err++; $display("FAIL init_words_before_rst: got %0d left want 1", sb.size());
                end
            end
            if (c >= 5 && c <= 18 && grant != '0) bad_gnt++;
            if (c == 19) begin
                n_cmp++;
                if (grant !== 4'b0100) begin
                    n_err++; $display("FAIL init_next_grant: got %b want 0100", grant);
                end
            end
            if (c == 2) begin
                fifo_init = 1'b1;
                load_pkt(2, 1, 18'h2C0);
                sb.push_back(18'h2C0);
            end
            if (c == 3) fifo_init = 1'b0;
        end
        n_cmp++;
        if (rst_cnt != 4 || first_rst != 6) begin
            n_err++; $display("FAIL init_rst_pulse: got len %0d start %0d want 4 6", rst_cnt, first_rst);
        end
        n_cmp++;
        if (bad_gnt != 0) begin
            n_err++; $display("FAIL init_no_grant: got %0d grant cycles want 0", bad_gnt);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL init_drain: got %0d left want 0", sb.size());
        end
    endtask

`ifdef FIFO_ARB_PROG_FULL_THROTTLE_EN
    task automatic test_prog_full();
        fifo_prog_full = 1'b1;
        load_pkt(1, 1, 18'h2E0);
        sb.push_back(18'h2E0);
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (grant !== '0) begin
                n_err++; $display("FAIL pf_hold[%0d]: got %b want 0000", c, grant);
            end
        end
        fifo_prog_full = 1'b0;
        step();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_err++; $display("FAIL pf_release: got %b want 0010", grant);
        end
        repeat (3) step();
    endtask
`else
    task automatic test_prog_full();
        fifo_prog_full = 1'b1;
        load_pkt(1, 1, 18'h2E0);
        sb.push_back(18'h2E0);
        step();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_err++; $display("FAIL pf_ignored: got %b want 0010", grant);
        end
        fifo_prog_full = 1'b0;
        repeat (3) step();
    endtask
`endif

    initial begin
        drive();
        test_reset();
        test_packets();
        test_round_robin();
        test_full_stall();
        test_init_mid_packet();
        test_prog_full();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL final_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
